watch_edit_ctrl: RTL and testbench

Control unit that sequences time-setting on the watch datapath. It conditions the raw mode/up/down push-buttons with a synchronizer, debounce and edge detect. It runs an edit-mode FSM that selects which field (hour, min, sec) is adjustable. It drives single-cycle up/down pulses with hold-to-repeat, an inactivity timeout back to run mode, and a blink strobe for the display of the selected field.

---
 rtl/watch_edit_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_watch_edit_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_edit_ctrl.sv
`default_nettype none
// ==== watch_edit_ctrl : button conditioning, edit-mode FSM, hold-to-repeat ====
// ==== inactivity timeout and blink strobe for time setting.     rev 1.0   ====
module watch_edit_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int BLINK_HALF      = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  output logic o_sel_hour,
  output logic o_sel_min,
  output logic o_sel_sec,
  output logic o_btn_up,
  output logic o_btn_down,
  output logic o_edit,
  output logic o_blink
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BL_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST   = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BL_W-1:0]  BL_LAST    = BL_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_SEC  = 2'd3
  } state_t;

  // Button vectors are ordered {down, up, mode}
  logic [2:0]      raw, sync1, sync2, deb, deb_d, evt;
  logic [DB_W-1:0] db_cnt [3];

  state_t          state, state_next;
  logic            rep_active, rep_active_next;
  logic            rep_dir, rep_dir_next;
  logic            rep_periodic, rep_periodic_next;
  logic [REP_W-1:0] rep_cnt, rep_cnt_next, rep_limit;
  logic [TO_W-1:0] idle_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic            pulse_up, pulse_down;
  logic            mode_evt, up_evt, down_evt, up_lvl, down_lvl;
  logic            in_edit, timeout_hit, state_change, rep_held;

  assign raw = {btn_down, btn_up, btn_mode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      evt   <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign mode_evt     = evt[0];
  assign up_evt       = evt[1];
  assign down_evt     = evt[2];
  assign up_lvl       = deb[1];
  assign down_lvl     = deb[2];
  assign in_edit      = (state != RUN);
  assign timeout_hit  = in_edit && (idle_cnt == TO_LAST);
  assign rep_limit    = rep_periodic ? PER_LAST : DELAY_LAST;
  assign rep_held     = rep_dir ? (down_lvl && !up_lvl) : (up_lvl && !down_lvl);
  assign state_change = (state_next != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Priority: mode press, then timeout, then up/down; anything that leaves
  // the repeat branch untouched falls back to the cleared defaults.
  always_comb begin
    state_next        = state;
    pulse_up          = 1'b0;
    pulse_down        = 1'b0;
    rep_active_next   = 1'b0;
    rep_dir_next      = rep_dir;
    rep_periodic_next = 1'b0;
    rep_cnt_next      = '0;
    if (mode_evt) begin
      case (state)
        RUN:       state_next = EDIT_HOUR;
        EDIT_HOUR: state_next = EDIT_MIN;
        EDIT_MIN:  state_next = EDIT_SEC;
        default:   state_next = RUN;
      endcase
    end else if (timeout_hit) begin
      state_next = RUN;
    end else if (in_edit) begin
      if (up_evt && !down_evt) begin
        pulse_up        = 1'b1;
        rep_active_next = 1'b1;
        rep_dir_next    = 1'b0;
      end else if (down_evt && !up_evt) begin
        pulse_down      = 1'b1;
        rep_active_next = 1'b1;
        rep_dir_next    = 1'b1;
      end else if (rep_active && rep_held) begin
        rep_active_next   = 1'b1;
        rep_periodic_next = rep_periodic;
        if (rep_cnt == rep_limit) begin
          pulse_up          = !rep_dir;
          pulse_down        = rep_dir;
          rep_periodic_next = 1'b1;
        end else begin
          rep_cnt_next = rep_cnt + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_active   <= 1'b0;
      rep_dir      <= 1'b0;
      rep_periodic <= 1'b0;
      rep_cnt      <= '0;
      idle_cnt     <= '0;
      blink_cnt    <= '0;
      o_blink      <= 1'b0;
      o_sel_hour   <= 1'b0;
      o_sel_min    <= 1'b0;
      o_sel_sec    <= 1'b0;
      o_edit       <= 1'b0;
      o_btn_up     <= 1'b0;
      o_btn_down   <= 1'b0;
    end else begin
      rep_active   <= rep_active_next;
      rep_dir      <= rep_dir_next;
      rep_periodic <= rep_periodic_next;
      rep_cnt      <= rep_cnt_next;

      if (state_change || pulse_up || pulse_down || !in_edit) idle_cnt <= '0;
      else                                                     idle_cnt <= idle_cnt + TO_W'(1);

      // Blink phase restarts high on every entry into an edit field
      if (state_change) begin
        blink_cnt <= '0;
        o_blink   <= (state_next != RUN);
      end else if (!in_edit) begin
        blink_cnt <= '0;
        o_blink   <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        o_blink   <= ~o_blink;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end

      o_sel_hour <= (state_next == EDIT_HOUR);
      o_sel_min  <= (state_next == EDIT_MIN);
      o_sel_sec  <= (state_next == EDIT_SEC);
      o_edit     <= (state_next != RUN);
      o_btn_up   <= pulse_up;
      o_btn_down <= pulse_down;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_watch_edit_ctrl.sv
`default_nettype none
// tb_watch_edit_ctrl: scoreboard bench for watch_edit_ctrl using short timing overrides.
module tb_watch_edit_ctrl;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int TO  = 200;
  localparam int BH  = 8;
  // Input driven at a falling edge with cycle count c; the first sampling edge
  // is c+1 and the registered pulse follows DB+3 edges later.
  localparam int LAT = 1 + DB + 3;
  localparam logic [1:0] K_UP = 2'b10;
  localparam logic [1:0] K_DN = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic o_sel_hour, o_sel_min, o_sel_sec, o_btn_up, o_btn_down, o_edit, o_blink;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ms = 0;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } exp_t;
  exp_t sb[$];

  watch_edit_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMEOUT_CYCLES (TO),
    .BLINK_HALF     (BH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .o_sel_hour(o_sel_hour),
    .o_sel_min (o_sel_min),
    .o_sel_sec (o_sel_sec),
    .o_btn_up  (o_btn_up),
    .o_btn_down(o_btn_down),
    .o_edit    (o_edit),
    .o_blink   (o_blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [1:0] kind);
    sb.push_back('{c, kind});
  endtask

  function automatic logic [2:0] sel_of(input int s);
    case (s)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] sel();
    return {o_sel_hour, o_sel_min, o_sel_sec};
  endfunction

  function automatic logic [6:0] outs();
    return {o_sel_hour, o_sel_min, o_sel_sec, o_btn_up, o_btn_down, o_edit, o_blink};
  endfunction

  task automatic mode_press(input bit with_up);
    btn_mode = 1'b1;
    if (with_up) btn_up = 1'b1;
    tick(LAT - 1);
    check_val("sel_before_mode", 32'(sel()), 32'(sel_of(ms)));
    tick(1);
    ms = (ms + 1) % 4;
    check_val("sel_after_mode", 32'(sel()), 32'(sel_of(ms)));
    check_val("edit_after_mode", 32'(o_edit), 32'(ms != 0));
    check_val("blink_on_entry", 32'(o_blink), 32'(ms != 0));
    tick(2);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    tick(10);
  endtask

  // Every DUT pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (o_btn_up || o_btn_down) begin
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", 32'({o_btn_up, o_btn_down}), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("pulse_kind", 32'({o_btn_up, o_btn_down}), 32'(e.kind));
        check_val("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    // Reset state and mode cycling
    tick(3);
    check_val("reset_outs", 32'(outs()), 32'd0);
    tick(1);
    check_val("reset_outs_hold", 32'(outs()), 32'd0);
    rst = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) mode_press(1'b0);

    // Debounce rejection and press latency in EDIT_MIN
    mode_press(1'b0);
    mode_press(1'b0);
    for (int g = 1; g <= 3; g++) begin
      btn_up = 1'b1;
      tick(g);
      btn_up = 1'b0;
      tick(8);
    end
    c = cyc;
    btn_up = 1'b1;
    push_exp(c + LAT, K_UP);
    tick(10);
    btn_up = 1'b0;
    tick(10);
    check_val("sb_drain_latency", 32'(sb.size()), 32'd0);

    // Auto-repeat in EDIT_SEC while down is held for 60 cycles
    mode_press(1'b0);
    c = cyc;
    btn_down = 1'b1;
    push_exp(c + LAT, K_DN);
    for (int t = c + LAT + RD; t <= c + 60 + 6; t += RP) push_exp(t, K_DN);
    tick(60);
    btn_down = 1'b0;
    tick(25);
    check_val("sb_drain_repeat", 32'(sb.size()), 32'd0);

    // RUN gating and conflicting events
    mode_press(1'b0);
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(10);
    mode_press(1'b0);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
    check_val("sel_after_updown", 32'(sel()), 32'(sel_of(ms)));
    mode_press(1'b1);
    check_val("sb_drain_conflict", 32'(sb.size()), 32'd0);

    // Blink cadence and inactivity timeout from EDIT_HOUR
    mode_press(1'b0);
    mode_press(1'b0);
    btn_mode = 1'b1;
    tick(LAT);
    ms = 1;
    check_val("to_entry_sel", 32'(sel()), 32'(sel_of(ms)));
    for (int k = 0; k < TO; k++) begin
      if (k == 2) btn_mode = 1'b0;
      if (k % 4 == 0) check_val("blink_phase", 32'(o_blink), 32'((k / BH) % 2 == 0));
      if (k == TO - 1) check_val("edit_before_timeout", 32'(o_edit), 32'd1);
      tick(1);
    end
    ms = 0;
    check_val("timeout_edit", 32'(o_edit), 32'd0);
    check_val("timeout_blink", 32'(o_blink), 32'd0);
    check_val("timeout_sel", 32'(sel()), 32'd0);
    tick(10);

    // An up press at cycle 150 of the edit pushes the timeout out
    btn_mode = 1'b1;
    tick(LAT);
    ms = 1;
    for (int k = 0; k < 150 + TO; k++) begin
      if (k == 2) btn_mode = 1'b0;
      if (k == 150 - LAT) begin
        btn_up = 1'b1;
        push_exp(cyc + LAT, K_UP);
      end
      if (k == 150 - LAT + 10) btn_up = 1'b0;
      if (k == TO) check_val("edit_extended", 32'(o_edit), 32'd1);
      if (k == 150 + TO - 1) check_val("edit_before_ext_timeout", 32'(o_edit), 32'd1);
      tick(1);
    end
    ms = 0;
    check_val("ext_timeout_edit", 32'(o_edit), 32'd0);
    check_val("sb_drain_timeout", 32'(sb.size()), 32'd0);
    tick(10);

    // Asynchronous reset while up is auto-repeating in EDIT_MIN
    mode_press(1'b0);
    mode_press(1'b0);
    c = cyc;
    btn_up = 1'b1;
    push_exp(c + LAT, K_UP);
    push_exp(c + LAT + RD, K_UP);
    tick(30);
    check_val("min_before_rst", 32'(sel()), 32'(sel_of(ms)));
    #1;
    rst = 1'b0;
    #1;
    check_val("async_rst_outs", 32'(outs()), 32'd0);
    tick(3);
    rst = 1'b1;
    ms = 0;
    tick(20);
    check_val("post_rst_sel", 32'(sel()), 32'd0);
    check_val("post_rst_edit", 32'(o_edit), 32'd0);
    btn_up = 1'b0;
    tick(10);
    check_val("sb_drain_final", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
